// File: rtl/top_out_unpack_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : top_out_unpack_arb_if
// Description : LII multi-channel input bus plus kernel-facing output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface top_out_unpack_arb_if #(
   parameter int P  = 2,
   parameter int PW = 128,
   parameter int W  = 64
);
   logic [P*PW-1:0] lii_in_tdata;
   logic [P-1:0]    lii_in_tvalid;
   logic [P-1:0]    lii_in_tready;
   logic [P*8-1:0]  lii_in_src;
   logic [P*8-1:0]  lii_in_dst;
   logic [W-1:0]    output_stream_tdata;
   logic            output_stream_tvalid;
   logic            output_stream_tready;

   modport master (
      output lii_in_tdata, lii_in_tvalid, lii_in_src, lii_in_dst, output_stream_tready,
      input  lii_in_tready, output_stream_tdata, output_stream_tvalid
   );

   modport slave (
      input  lii_in_tdata, lii_in_tvalid, lii_in_src, lii_in_dst, output_stream_tready,
      output lii_in_tready, output_stream_tdata, output_stream_tvalid
   );
endinterface
`default_nettype wire

// File: rtl/top_out_unpack_arb.sv
`default_nettype none
// ============================================================================
// Module      : top_out_unpack_arb
// Description : Round-robin merge of P LII channels into one kernel stream,
//               with destination filtering, truncation and a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module top_out_unpack_arb #(
   parameter int         P      = 2,
   parameter int         PW     = 128,
   parameter int         W      = 64,
   parameter int         DEPTH  = 4,
   parameter int         FILTER = 1,
   parameter logic [7:0] MY_ID  = 8'h00
) (
   input  wire logic              aclk,
   input  wire logic              arst,
   top_out_unpack_arb_if.slave    bus,
   output logic                   ce,
   output logic [7:0]             last_src,
   output logic [15:0]            drop_count
);
   localparam int                 c_PTR_W  = (P > 1) ? $clog2(P) : 1;
   localparam int                 c_AW     = $clog2(DEPTH);
   localparam int                 c_CNT_W  = c_AW + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
   localparam logic [c_AW-1:0]    c_A_ONE  = c_AW'(1);
   localparam logic [c_PTR_W-1:0] c_LAST   = c_PTR_W'(P - 1);
   localparam logic [c_PTR_W-1:0] c_P_ONE  = c_PTR_W'(1);
   localparam logic               c_FILTER = (FILTER != 0);

   logic [W-1:0]         w_data [P];
   logic [7:0]           w_src  [P];
   logic [7:0]           w_dst  [P];
   logic                 w_unused;

   logic [c_PTR_W-1:0]   r_rr;
   logic [c_AW-1:0]      r_wr;
   logic [c_AW-1:0]      r_rd;
   logic [c_CNT_W-1:0]   r_count;
   logic                 r_ce;
   logic [7:0]           r_last_src;
   logic [15:0]          r_drop_count;
   logic [W-1:0]         r_mem [DEPTH];

   logic                 w_found;
   logic [c_PTR_W-1:0]   w_cand;
   logic [c_PTR_W-1:0]   w_scan;
   logic                 w_drop;
   logic                 w_full;
   logic                 w_grant;
   logic                 w_push;
   logic                 w_pop;
   logic [P-1:0]         w_tready;
   logic [c_PTR_W-1:0]   w_rr_next;
   logic [c_CNT_W-1:0]   w_count_next;

   for (genvar c = 0; c < P; c++) begin : g_unpack
      assign w_data[c] = bus.lii_in_tdata[c*PW +: W];
      assign w_src[c]  = bus.lii_in_src[c*8 +: 8];
      assign w_dst[c]  = bus.lii_in_dst[c*8 +: 8];
   end

   // Payload bits above W are deliberately discarded.
   assign w_unused = ^bus.lii_in_tdata;

   always_comb begin
      w_found = 1'b0;
      w_cand  = '0;
      w_scan  = '0;
      for (int i = 0; i < P; i++) begin
         w_scan = c_PTR_W'((int'(r_rr) + i) % P);
         if (!w_found && bus.lii_in_tvalid[w_scan]) begin
            w_found = 1'b1;
            w_cand  = w_scan;
         end
      end
   end

   // Drops never occupy the FIFO, so they stay grantable while it is full.
   assign w_drop    = c_FILTER && (w_dst[w_cand] != MY_ID);
   assign w_full    = (r_count == c_DEPTH);
   assign w_grant   = w_found && (!w_full || w_drop) && !arst;
   assign w_push    = w_grant && !w_drop;
   assign w_pop     = (r_count != '0) && bus.output_stream_tready;
   assign w_rr_next = (w_cand == c_LAST) ? '0 : w_cand + c_P_ONE;

   always_comb begin
      w_tready = '0;
      if (w_grant) begin
         w_tready[w_cand] = 1'b1;
      end
   end

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + c_ONE;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - c_ONE;
      end
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_rr         <= '0;
         r_wr         <= '0;
         r_rd         <= '0;
         r_count      <= '0;
         r_ce         <= 1'b0;
         r_last_src   <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_grant) begin
            r_rr <= w_rr_next;
         end
         if (w_push) begin
            r_wr       <= r_wr + c_A_ONE;
            r_last_src <= w_src[w_cand];
         end
         if (w_grant && w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
         end
         if (w_pop) begin
            r_rd <= r_rd + c_A_ONE;
         end
         r_count <= w_count_next;
         r_ce    <= (w_count_next != c_DEPTH);
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge aclk) begin
      if (w_push) begin
         r_mem[r_wr] <= w_data[w_cand];
      end
   end

   assign bus.lii_in_tready        = w_tready;
   assign bus.output_stream_tdata  = r_mem[r_rd];
   assign bus.output_stream_tvalid = (r_count != '0);
   assign ce                       = r_ce;
   assign last_src                 = r_last_src;
   assign drop_count               = r_drop_count;
endmodule
`default_nettype wire

// File: doc/top_out_unpack_arb.md
Name: top_out_unpack_arb

Overview:
- Parametrised successor to the single-channel LII output unwrapper.
- Merges P LII physical input channels into one kernel-facing stream using round-robin arbitration.
- Optionally filters flits by destination ID, truncates each flit from PW to W bits, and buffers payloads in a DEPTH-entry FIFO.
- Sits between the LII fabric and an HLS kernel's output_stream port and drives the kernel clock enable.

Parameters:
- P, 2: number of LII phy input channels (1..8).
- PW, 128: LII packing width in bits.
- W, 64: kernel stream width in bits, W <= PW; payload = tdata[W-1:0] of each flit.
- DEPTH, 4: FIFO entries, power of two, >= 2.
- FILTER, 1: 1 = drop flits whose dst != MY_ID; 0 = accept all flits.
- MY_ID, 8'h00: this node's LII destination ID.

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- arst  in  1  asynchronous, active-high reset.
- lii_in_tdata  in  P*PW  channel c occupies bits [c*PW +: PW].
- lii_in_tvalid  in  P  per-channel valid.
- lii_in_tready  out  P  per-channel ready; at most one bit high per cycle.
- lii_in_src  in  P*8  per-channel source ID.
- lii_in_dst  in  P*8  per-channel destination ID.
- output_stream_tdata  out  W  FIFO head payload.
- output_stream_tvalid  out  1  FIFO non-empty.
- output_stream_tready  in  1  kernel accepts the head.
- ce  out  1  kernel clock enable.
- last_src  out  8  src of the most recently pushed flit.
- drop_count  out  16  number of filtered-out flits, saturating.

Behaviour:
- Reset (arst high, asynchronous):
  - FIFO empties; rd/wr pointers and count go to 0; round-robin pointer rr goes to 0.
  - Outputs: output_stream_tvalid=0, lii_in_tready=0, ce=0, last_src=0, drop_count=0.
  - Reset asserted mid-transfer discards buffered data; nothing is accepted while arst is high. Deassertion takes effect on the next aclk edge.
- Arbitration (combinational each cycle):
  - Candidate = first channel c, scanning from rr upward modulo P, whose tvalid=1.
  - grant is valid only if a candidate exists AND (full=0 OR the candidate flit is a drop).
  - A flit is a drop when FILTER=1 and dst != MY_ID.
  - lii_in_tready[c]=1 only for the granted channel; all other bits are 0. ready may depend on valid; valid must never depend on ready.
- Handshake on channel c (tvalid[c] & tready[c]):
  - rr <= (c+1) mod P.
  - If not a drop: push tdata[W-1:0] into the FIFO and set last_src <= src[c].
  - If a drop: no push; drop_count increments, saturating at 16'hFFFF.
  - rr does not move in cycles with no handshake.
- FIFO:
  - Registered storage; a pushed word is visible at output_stream_tdata/tvalid the cycle after the push. Minimum latency is 1 cycle.
  - Pop on output_stream_tvalid & output_stream_tready.
  - Push and pop in the same cycle: count unchanged; allowed whenever not full.
  - Full (count==DEPTH) blocks pushes even if a pop occurs that cycle; the push is accepted the cycle after. This is a registered-full decision.
  - Pointers wrap modulo DEPTH. A pop while empty is impossible because tvalid=0.
- ce:
  - Registered; ce <= ~full_next, where full_next is the count after this cycle's push/pop equals DEPTH.
  - ce is low while the FIFO is full. This stalls the kernel so it cannot build up further upstream demand.
  - ce is 0 during reset and 1 from the first cycle after reset release onward while not full.
- Arithmetic and widths:
  - count is clog2(DEPTH)+1 bits.
  - rr and the grant index are clog2(P) bits; for P=1 the pointer is held at 0.
  - Bits tdata[PW-1:W] are ignored.

Test Plan:
- Single flit: P=2, ch0 valid with tdata[63:0]=64'hDEAD_BEEF_0000_0001, dst=MY_ID, src=8'h05, kernel ready=1 -> tready[0]=1 same cycle; output tvalid=1 with that data one cycle later; last_src=8'h05; ce stays 1.
- Fairness: ch0 and ch1 both continuously valid, kernel ready=1 -> grants alternate 0,1,0,1; each channel gets exactly 4 of 8 grants; tready is never high on both channels.
- Backpressure/full: DEPTH=4, kernel ready=0, push 4 flits -> count=4, all tready=0, ce=0 the cycle after the 4th push; raise ready for 1 cycle -> one pop, next push is accepted the following cycle, ce returns to 1.
- Filter: FILTER=1, MY_ID=8'h03, ch1 sends 3 flits with dst=8'h07 while the FIFO is full -> all 3 accepted (tready=1), no push, drop_count=3, FIFO contents unchanged.
- Saturation: force 65537 drops -> drop_count holds 16'hFFFF.
- Reset mid-op: FIFO holding 3 words, assert arst asynchronously mid-cycle -> output_stream_tvalid, ce, and tready drop immediately; after release, output is empty and the first new flit appears with 1-cycle latency from ch0 (rr=0).
